// File: rtl/pipelined_divider_v2.sv
// pipelined_divider_v2: fully pipelined restoring integer divider, BPS quotient bits per stage
//   clk_in, rst_n_in           clock, asynchronous active-low reset
//   dividend_in, divisor_in    operands (unsigned or two's complement per SIGNED)
//   tag_in, valid_in, ready_out  operation tag and input handshake
//   quotient_out, remainder_out, tag_out, error_out  result (error = divide by zero)
//   valid_out, ready_in        output handshake
//   busy_out                   any stage holds a valid operation
module pipelined_divider_v2 #(
    parameter int WIDTH     = 32,
    parameter int BPS       = 2,
    parameter int SIGNED    = 0,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 error_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 busy_out
);
    localparam int S = WIDTH / BPS;
    // index 0 is the input stage, 1..S are the iteration stages
    logic [S:0]           v_q, v_d, qn_q, qn_d, rn_q, rn_d, z_q, z_d;
    logic [WIDTH-1:0]     rem_q [S+1];
    logic [WIDTH-1:0]     rem_d [S+1];
    logic [WIDTH-1:0]     aq_q  [S+1];
    logic [WIDTH-1:0]     aq_d  [S+1];
    logic [WIDTH-1:0]     b_q   [S+1];
    logic [WIDTH-1:0]     b_d   [S+1];
    logic [WIDTH-1:0]     dvd_q [S+1];
    logic [WIDTH-1:0]     dvd_d [S+1];
    logic [TAG_WIDTH-1:0] tag_q [S+1];
    logic [TAG_WIDTH-1:0] tag_d [S+1];
    logic                 vo_q, vo_d, err_q, err_d;
    logic [WIDTH-1:0]     quo_q, quo_d, rmd_q, rmd_d;
    logic [TAG_WIDTH-1:0] tgo_q, tgo_d;
    logic                 en;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return (SIGNED != 0 && x[WIDTH-1]) ? -x : x;
    endfunction

    // aq starts as the dividend magnitude; its MSBs feed the partial remainder while
    // quotient bits shift in from the bottom, so after S stages it holds the quotient
    function automatic logic [2*WIDTH-1:0] iter(input logic [WIDTH-1:0] rem, aq, b);
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] r, q;
        r = rem;
        q = aq;
        for (int i = 0; i < BPS; i++) begin
            t = {r, q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, b}) begin
                t    = t - {1'b0, b};
                q[0] = 1'b1;
            end
            r = t[WIDTH-1:0];
        end
        return {r, q};
    endfunction

    assign en            = !vo_q || ready_in;
    assign ready_out     = en;
    assign busy_out      = vo_q || (|v_q);
    assign valid_out     = vo_q;
    assign quotient_out  = quo_q;
    assign remainder_out = rmd_q;
    assign tag_out       = tgo_q;
    assign error_out     = err_q;

    always_comb begin
        v_d   = v_q;
        qn_d  = qn_q;
        rn_d  = rn_q;
        z_d   = z_q;
        rem_d = rem_q;
        aq_d  = aq_q;
        b_d   = b_q;
        dvd_d = dvd_q;
        tag_d = tag_q;
        vo_d  = vo_q;
        err_d = err_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        tgo_d = tgo_q;
        if (en) begin
            v_d[0]   = valid_in;
            qn_d[0]  = (SIGNED != 0) && (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
            rn_d[0]  = (SIGNED != 0) && dividend_in[WIDTH-1];
            z_d[0]   = divisor_in == '0;
            rem_d[0] = '0;
            aq_d[0]  = mag(dividend_in);
            b_d[0]   = mag(divisor_in);
            dvd_d[0] = dividend_in;
            tag_d[0] = tag_in;
            for (int k = 1; k <= S; k++) begin
                v_d[k]               = v_q[k-1];
                qn_d[k]              = qn_q[k-1];
                rn_d[k]              = rn_q[k-1];
                z_d[k]               = z_q[k-1];
                {rem_d[k], aq_d[k]}  = iter(rem_q[k-1], aq_q[k-1], b_q[k-1]);
                b_d[k]               = b_q[k-1];
                dvd_d[k]             = dvd_q[k-1];
                tag_d[k]             = tag_q[k-1];
            end
            vo_d = v_q[S];
            // bubbles leave the previous result on the outputs
            if (v_q[S]) begin
                err_d = z_q[S];
                quo_d = z_q[S] ? '1 : qn_q[S] ? -aq_q[S] : aq_q[S];
                rmd_d = z_q[S] ? dvd_q[S] : rn_q[S] ? -rem_q[S] : rem_q[S];
                tgo_d = tag_q[S];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_q  <= '0;
            qn_q <= '0;
            rn_q <= '0;
            z_q  <= '0;
            for (int k = 0; k <= S; k++) begin
                rem_q[k] <= '0;
                aq_q[k]  <= '0;
                b_q[k]   <= '0;
                dvd_q[k] <= '0;
                tag_q[k] <= '0;
            end
            vo_q  <= 1'b0;
            err_q <= 1'b0;
            quo_q <= '0;
            rmd_q <= '0;
            tgo_q <= '0;
        end else begin
            v_q   <= v_d;
            qn_q  <= qn_d;
            rn_q  <= rn_d;
            z_q   <= z_d;
            rem_q <= rem_d;
            aq_q  <= aq_d;
            b_q   <= b_d;
            dvd_q <= dvd_d;
            tag_q <= tag_d;
            vo_q  <= vo_d;
            err_q <= err_d;
            quo_q <= quo_d;
            rmd_q <= rmd_d;
            tgo_q <= tgo_d;
        end
    end
endmodule

// File: tb/tb_pipelined_divider_v2.sv
// tb_pipelined_divider_v2: five divider configurations fed one stimulus stream, checked against an arithmetic model
module tb_pipelined_divider_v2;
    localparam int NU = 5;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  t;
        int          c;
        bit          l;
    } op_t;

    logic          clk, rst_n, vin, rin;
    logic [31:0]   dvd, dvs;
    logic [3:0]    tag;
    logic [NU-1:0] rdy, vo, err, bsy;
    logic [31:0]   qo [NU];
    logic [31:0]   ro [NU];
    logic [3:0]    to [NU];
    int            cyc, n_cmp, n_bad;
    int            pend [NU];
    bit            chk_lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // result packed as {error, tag, quotient, remainder}, each word masked to w bits
    function automatic logic [68:0] ref_div(input int w, input int sg, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] t);
        longint m, x, y, q, r;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (y == 0) return {1'b1, t, 32'(m), 32'(x)};
        if (sg != 0) begin
            if (x > m / 2) x = x - m - 1;
            if (y > m / 2) y = y - m - 1;
        end
        q = x / y;
        r = x % y;
        return {1'b0, t, 32'(q & m), 32'(r & m)};
    endfunction

    genvar g;
    for (g = 0; g < NU; g++) begin : u
        localparam int W  = g >= 2 ? 16 : 32;
        localparam int B  = g == 2 ? 1 : g == 4 ? 4 : 2;
        localparam int SG = g == 1 ? 1 : 0;
        localparam int L  = W / B + 2;
        logic [W-1:0] q, r;
        op_t          sb [$];
        op_t          op;
        logic [68:0]  held;
        bit           stalled;
        pipelined_divider_v2 #(.WIDTH(W), .BPS(B), .SIGNED(SG), .TAG_WIDTH(4)) dut (
            .clk_in(clk), .rst_n_in(rst_n), .dividend_in(dvd[W-1:0]), .divisor_in(dvs[W-1:0]),
            .tag_in(tag), .valid_in(vin), .ready_out(rdy[g]), .quotient_out(q),
            .remainder_out(r), .tag_out(to[g]), .error_out(err[g]), .valid_out(vo[g]),
            .ready_in(rin), .busy_out(bsy[g]));
        assign qo[g] = 32'(q);
        assign ro[g] = 32'(r);
        // inputs change just after posedge, so at negedge the handshake for the next edge is settled
        always @(negedge clk) begin
            if (!rst_n) begin
                sb.delete();
                pend[g] = 0;
                stalled = 0;
            end else begin
                chk($sformatf("ready%0d", g), 96'(rdy[g]), 96'(!(vo[g] && !rin)));
                if (stalled) chk($sformatf("hold%0d", g), 96'({err[g], to[g], qo[g], ro[g]}), 96'(held));
                stalled = vo[g] && !rin;
                held = {err[g], to[g], qo[g], ro[g]};
                if (vo[g] && rin) begin
                    if (sb.size() == 0) chk($sformatf("spurious%0d", g), 96'(vo[g]), 96'(0));
                    else begin
                        op = sb.pop_front();
                        pend[g]--;
                        chk($sformatf("result%0d", g), 96'({err[g], to[g], qo[g], ro[g]}),
                            96'(ref_div(W, SG, op.a, op.b, op.t)));
                        if (op.l) chk($sformatf("latency%0d", g), 96'(cyc - op.c), 96'(L));
                    end
                end
                if (vin && rdy[g]) begin
                    sb.push_back('{dvd, dvs, tag, cyc, chk_lat});
                    pend[g]++;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic r);
        @(posedge clk);
        #1;
        vin = v; dvd = a; dvs = b; tag = t; rin = r;
    endtask

    task automatic drain();
        int n = 0;
        step(0, 0, 0, 0, 1);
        while (bsy != 0 && n < 300) begin
            step(0, 0, 0, 0, 1);
            n++;
        end
        chk("drain", 96'(bsy), 96'(0));
    endtask

    task automatic chk_idle(input string nm);
        for (int i = 0; i < NU; i++)
            chk($sformatf("%s%0d", nm, i), 96'({vo[i], bsy[i], err[i], to[i], qo[i], ro[i]}), 96'(0));
    endtask

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 4);
        return k == 0 ? 32'h8000_0000 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'($urandom_range(0, 15)) :
               k == 3 ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
    endfunction

    initial begin
        clk = 0; rst_n = 1; vin = 0; rin = 1; dvd = 0; dvs = 0; tag = 0; chk_lat = 0;
        cyc = 0; n_cmp = 0; n_bad = 0;
        for (int i = 0; i < NU; i++) pend[i] = 0;
        #2 rst_n = 0;
        #10 chk_idle("reset");
        #11 rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", 96'(rdy), 96'({NU{1'b1}}));

        chk_lat = 1;
        step(1, 100, 7, 1, 1);
        step(1, 32'hFFFF_FFFF, 1, 2, 1);
        step(1, 5, 9, 3, 1);
        step(1, 1234, 0, 4, 1);
        step(1, -32'sd7, 2, 5, 1);
        step(1, 7, -32'sd2, 6, 1);
        step(1, 32'h8000_0000, 32'hFFFF_FFFF, 7, 1);
        step(1, 32'h0000_8000, 32'h0000_FFFF, 8, 1);
        step(1, 0, 0, 9, 1);
        drain();

        for (int d = 0; d < 256; d++) step(1, $urandom, 32'(d), 4'(d), 1);
        drain();

        chk_lat = 0;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, pick(), pick(), 4'($urandom), 1'($urandom));
        drain();

        chk_lat = 1;
        for (int i = 0; i < 5; i++) step(1, $urandom, $urandom_range(1, 99), 4'(i), 1);
        @(posedge clk);
        #2 vin = 0; rst_n = 0;
        #1 chk_idle("midreset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("ready_after_midreset", 96'(rdy), 96'({NU{1'b1}}));
        step(1, 9, 3, 4'hA, 1);
        drain();

        for (int i = 0; i < NU; i++) chk($sformatf("pending%0d", i), 96'(pend[i]), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
